// File: rtl/change_dispenser.sv
// Change dispenser: pays a latched balance back out as coins over a valid/ready
// handshake, largest denomination first, skipping denominations that are out of stock.
module change_dispenser #(
    parameter int TOTAL_BITS = 31,
    parameter int STOCK_BITS = 8,
    parameter int COIN0_VAL  = 100,
    parameter int COIN1_VAL  = 500,
    parameter int COIN2_VAL  = 1000,
    parameter int INIT_STOCK = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    input  logic [TOTAL_BITS-1:0] i_amount,
    input  logic                  i_refill,
    input  logic                  i_coin_ready,
    output logic                  o_coin_valid,
    output logic [1:0]            o_coin_idx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [TOTAL_BITS-1:0] o_remainder,
    output logic [STOCK_BITS-1:0] o_stock0,
    output logic [STOCK_BITS-1:0] o_stock1,
    output logic [STOCK_BITS-1:0] o_stock2
);

    typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_t;

    localparam logic [TOTAL_BITS-1:0] VAL0 = TOTAL_BITS'(COIN0_VAL);
    localparam logic [TOTAL_BITS-1:0] VAL1 = TOTAL_BITS'(COIN1_VAL);
    localparam logic [TOTAL_BITS-1:0] VAL2 = TOTAL_BITS'(COIN2_VAL);
    localparam logic [STOCK_BITS-1:0] FULL = STOCK_BITS'(INIT_STOCK);

    state_t                state;
    state_t                next_state;
    logic [TOTAL_BITS-1:0] remaining;
    logic [STOCK_BITS-1:0] stock [3];
    logic                  has_sel;
    logic [1:0]            sel;
    logic [TOTAL_BITS-1:0] sel_val;
    logic                  transfer;

    // Largest denomination that fits the balance and is still in stock.
    always_comb begin
        has_sel = 1'b1;
        sel     = 2'd0;
        sel_val = VAL0;
        if (remaining >= VAL2 && stock[2] != '0) begin
            sel     = 2'd2;
            sel_val = VAL2;
        end else if (remaining >= VAL1 && stock[1] != '0) begin
            sel     = 2'd1;
            sel_val = VAL1;
        end else if (remaining >= VAL0 && stock[0] != '0) begin
            sel     = 2'd0;
            sel_val = VAL0;
        end else begin
            has_sel = 1'b0;
        end
    end

    assign transfer = (state == DISPENSE) && has_sel && i_coin_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (i_start) next_state = DISPENSE;
            DISPENSE: if (!has_sel) next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        o_coin_valid = 1'b0;
        o_coin_idx   = 2'd0;
        if (state == DISPENSE && has_sel) begin
            o_coin_valid = 1'b1;
            o_coin_idx   = sel;
        end
    end

    // Remainder is captured on entry to DONE so it is already valid while o_done is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            remaining   <= '0;
            o_remainder <= '0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
            for (int k = 0; k < 3; k++) stock[k] <= FULL;
        end else begin
            o_done <= (next_state == DONE);
            o_busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (i_start) begin
                        remaining   <= i_amount;
                        o_remainder <= '0;
                    end
                    if (i_refill) begin
                        for (int k = 0; k < 3; k++) stock[k] <= FULL;
                    end
                end
                DISPENSE: begin
                    if (transfer) begin
                        remaining <= remaining - sel_val;
                        for (int k = 0; k < 3; k++) begin
                            if (sel == 2'(k)) stock[k] <= stock[k] - STOCK_BITS'(1);
                        end
                    end
                    if (!has_sel) o_remainder <= remaining;
                end
                default: ;
            endcase
        end
    end

    assign o_stock0 = stock[0];
    assign o_stock1 = stock[1];
    assign o_stock2 = stock[2];

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized self-checking bench for change_dispenser against a per-denomination
// greedy payout model.
module tb_change_dispenser;

    localparam int TOTAL_BITS = 31;
    localparam int STOCK_BITS = 8;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  i_start = 1'b0;
    logic [TOTAL_BITS-1:0] i_amount = '0;
    logic                  i_refill = 1'b0;
    logic                  i_coin_ready = 1'b0;
    logic                  o_coin_valid;
    logic [1:0]            o_coin_idx;
    logic                  o_busy;
    logic                  o_done;
    logic [TOTAL_BITS-1:0] o_remainder;
    logic [STOCK_BITS-1:0] o_stock0;
    logic [STOCK_BITS-1:0] o_stock1;
    logic [STOCK_BITS-1:0] o_stock2;

    int total = 0;
    int bad = 0;
    int coin_val [3] = '{100, 500, 1000};
    int mstock [3];

    change_dispenser dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_start      (i_start),
        .i_amount     (i_amount),
        .i_refill     (i_refill),
        .i_coin_ready (i_coin_ready),
        .o_coin_valid (o_coin_valid),
        .o_coin_idx   (o_coin_idx),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_remainder  (o_remainder),
        .o_stock0     (o_stock0),
        .o_stock1     (o_stock1),
        .o_stock2     (o_stock2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic checkStocks(input string tag);
        checkOutput({tag, "_stock0"}, o_stock0, mstock[0]);
        checkOutput({tag, "_stock1"}, o_stock1, mstock[1]);
        checkOutput({tag, "_stock2"}, o_stock2, mstock[2]);
    endtask

    // One return transaction: start at cycle N (t=0), then watch every cycle until o_done.
    task automatic applyStimulus(input int amount, input bit refill, input int stall,
                                 input int ready_pct, input bit poke);
        int exp_q[$];
        int rem;
        int n;
        int t;
        int last_xfer;
        int ncoins;
        bit finished;
        bit ready;
        bit prev_valid;
        bit prev_ready;
        logic [1:0] prev_idx;

        @(negedge clk);
        i_start      = 1'b1;
        i_amount     = TOTAL_BITS'(amount);
        i_refill     = refill;
        i_coin_ready = 1'b0;

        if (refill) mstock = '{10, 10, 10};
        rem = amount;
        for (int k = 2; k >= 0; k--) begin
            n = rem / coin_val[k];
            if (n > mstock[k]) n = mstock[k];
            for (int j = 0; j < n; j++) exp_q.push_back(k);
            rem -= n * coin_val[k];
            mstock[k] -= n;
        end
        ncoins     = exp_q.size();
        t          = 0;
        last_xfer  = 0;
        finished   = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_idx   = 2'd0;

        while (!finished && t < 200) begin
            @(negedge clk);
            t++;
            i_start  = 1'b0;
            i_refill = 1'b0;
            if (t == 1) begin
                checkOutput("first_valid", o_coin_valid, (ncoins > 0) ? 1 : 0);
                checkOutput("busy", o_busy, 1);
            end
            if (prev_valid && !prev_ready) begin
                checkOutput("hold_valid", o_coin_valid, 1);
                checkOutput("hold_idx", o_coin_idx, prev_idx);
            end
            if (o_done) begin
                finished = 1'b1;
                checkOutput("done_time", t, (ncoins > 0) ? last_xfer + 2 : 2);
                checkOutput("remainder", o_remainder, rem);
                checkOutput("coins_missing", exp_q.size(), 0);
                checkStocks("done");
            end else begin
                ready = (t > stall) && ($urandom_range(99) < ready_pct);
                if (o_coin_valid && ready) begin
                    if (exp_q.size() == 0) checkOutput("extra_coin", o_coin_idx + 1, 0);
                    else checkOutput("coin_idx", o_coin_idx, exp_q.pop_front());
                    last_xfer = t;
                end
                i_coin_ready = ready;
                prev_valid   = o_coin_valid;
                prev_ready   = ready;
                prev_idx     = o_coin_idx;
                if (poke && t == 2) begin
                    i_start  = 1'b1;
                    i_amount = TOTAL_BITS'(123);
                    i_refill = 1'b1;
                end
            end
        end
        i_coin_ready = 1'b0;
        i_start      = 1'b0;
        i_refill     = 1'b0;
        if (!finished) checkOutput("timeout", 0, 1);
        @(negedge clk);
        checkOutput("done_pulse_end", o_done, 0);
        checkOutput("idle_busy", o_busy, 0);
    endtask

    task automatic doRefill();
        @(negedge clk);
        i_refill = 1'b1;
        @(negedge clk);
        i_refill = 1'b0;
        mstock = '{10, 10, 10};
        checkStocks("refill");
    endtask

    initial begin
        int done_seen;
        int amt;

        mstock = '{10, 10, 10};
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", o_coin_valid, 0);
        checkOutput("rst_idx", o_coin_idx, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_remainder", o_remainder, 0);
        checkStocks("rst");
        reset_n = 1'b1;

        applyStimulus(1600, 1'b0, 0, 100, 1'b0);
        applyStimulus(1600, 1'b1, 3, 100, 1'b0);
        doRefill();
        applyStimulus(10000, 1'b0, 0, 100, 1'b0);
        applyStimulus(2000, 1'b0, 0, 100, 1'b0);
        applyStimulus(150, 1'b0, 0, 100, 1'b0);
        applyStimulus(0, 1'b0, 0, 100, 1'b0);
        applyStimulus(3700, 1'b0, 1, 60, 1'b1);
        doRefill();

        for (int i = 0; i < 40; i++) begin
            amt = $urandom_range(5000);
            if ($urandom_range(1) == 1) amt = amt - (amt % 50);
            applyStimulus(amt, ($urandom_range(4) == 0), $urandom_range(2),
                          $urandom_range(100, 40), ($urandom_range(3) == 0));
        end

        // Reset after the second coin of a 1600 return, with the third coin on offer.
        doRefill();
        @(negedge clk);
        i_start      = 1'b1;
        i_amount     = TOTAL_BITS'(1600);
        i_coin_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        mstock = '{10, 10, 10};
        checkOutput("abort_valid", o_coin_valid, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkStocks("abort");
        reset_n      = 1'b1;
        i_coin_ready = 1'b0;
        done_seen    = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_done) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
